onchip_mem_responder: RTL and testbench

- Responder end of the on-chip memory request interface driven by the MMU controller.
- Accepts single or burst read/write requests, services them from an internal word-addressed storage array, and returns data beats.
- Asserts `onc_resp` on the final beat of each transaction.
- Sits between the MMU datapath (on-chip addr/data registers) and the on-chip storage.

---
 rtl/onchip_mem_responder.sv | 148 ++++++++++++++
 tb/tb_onchip_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_responder.sv
// Responder for the on-chip memory request interface: single/burst reads and writes to a word array.
// Optional per-word even parity checking is enabled by defining ONC_PARITY_EN.
module onchip_mem_responder #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  onc_read,
  input  logic                  onc_write,
  input  logic [ADDR_WIDTH-1:0] onc_addr,
  input  logic [2:0]            onc_burst_len,
  input  logic [DATA_WIDTH-1:0] onc_wdata,
  output logic                  onc_wdata_ready,
  output logic [DATA_WIDTH-1:0] onc_rdata,
  output logic                  onc_rdata_valid,
  output logic                  onc_resp,
  output logic                  onc_busy
`ifdef ONC_PARITY_EN
  ,
  output logic                  onc_parity_err
`endif
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [2:0] MAX_LEN  = 3'(MAX_BURST);
  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BEAT,
    WR_BEAT,
    DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_beats;
  logic [2:0]            r_lat;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [2:0]            w_len;
  logic [DATA_WIDTH-1:0] w_rword;
  logic                  w_rdBeat;
  logic                  w_wrBeat;
  logic                  w_lastBeat;

  // A zero length still moves one word; anything beyond the burst limit is clamped.
  always_comb begin
    w_len = onc_burst_len;
    if (onc_burst_len == 3'd0) begin
      w_len = 3'd1;
    end else if (onc_burst_len > MAX_LEN) begin
      w_len = MAX_LEN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_beats <= '0;
      r_lat   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (onc_read) begin
            r_addr  <= onc_addr;
            r_beats <= w_len;
            r_lat   <= LAT_LOAD;
            r_state <= RD_WAIT;
          end else if (onc_write) begin
            r_addr  <= onc_addr;
            r_beats <= w_len;
            r_state <= WR_BEAT;
          end
        end
        RD_WAIT: begin
          if (r_lat == 3'd0) begin
            r_state <= RD_BEAT;
          end else begin
            r_lat <= r_lat - 3'd1;
          end
        end
        RD_BEAT, WR_BEAT: begin
          r_addr  <= r_addr + 1'b1;
          r_beats <= r_beats - 3'd1;
          if (r_beats == 3'd1) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // Wait for the requester to drop its level request so it cannot re-trigger.
          if (!onc_read && !onc_write) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_rdBeat   = (r_state == RD_BEAT);
  assign w_wrBeat   = (r_state == WR_BEAT);
  assign w_lastBeat = (r_beats == 3'd1);
  assign w_rword    = r_mem[r_addr];

  // Storage has no reset; the rst guard drops a beat that is in flight when reset hits.
  always_ff @(posedge clk) begin
    if (!rst && w_wrBeat) begin
      r_mem[r_addr] <= onc_wdata;
    end
  end

  always_comb begin
    onc_wdata_ready = w_wrBeat;
    onc_rdata_valid = w_rdBeat;
    onc_rdata       = w_rdBeat ? w_rword : '0;
    onc_resp        = (w_rdBeat || w_wrBeat) && w_lastBeat;
    onc_busy        = (r_state != IDLE);
  end

`ifdef ONC_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic [DEPTH-1:0] r_pvalid;

  always_ff @(posedge clk) begin
    if (!rst && w_wrBeat) begin
      r_par[r_addr] <= ^onc_wdata;
    end
  end

  // Words never written are treated as parity-clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pvalid <= '0;
    end else if (w_wrBeat) begin
      r_pvalid[r_addr] <= 1'b1;
    end
  end

  assign onc_parity_err = w_rdBeat && r_pvalid[r_addr] && ((^w_rword) != r_par[r_addr]);
`endif

endmodule

// File: tb/tb_onchip_mem_responder.sv
// Self-checking bench for onchip_mem_responder: directed corner cases plus randomized traffic
// checked against an array model of the memory and per-cycle timing derived from transaction length.
module tb_onchip_mem_responder;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          onc_read;
  logic          onc_write;
  logic [AW-1:0] onc_addr;
  logic [2:0]    onc_burst_len;
  logic [DW-1:0] onc_wdata;
  logic          onc_wdata_ready;
  logic [DW-1:0] onc_rdata;
  logic          onc_rdata_valid;
  logic          onc_resp;
  logic          onc_busy;
`ifdef ONC_PARITY_EN
  logic          onc_parity_err;
  int            corruptAddr = -1;
`endif

  int testCount = 0;
  int failCount = 0;

  logic [DW-1:0] model   [256];
  bit            written [256];
  logic [DW-1:0] wbuf    [8];

  onchip_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .onc_read(onc_read), .onc_write(onc_write),
    .onc_addr(onc_addr), .onc_burst_len(onc_burst_len),
    .onc_wdata(onc_wdata), .onc_wdata_ready(onc_wdata_ready),
    .onc_rdata(onc_rdata), .onc_rdata_valid(onc_rdata_valid),
    .onc_resp(onc_resp), .onc_busy(onc_busy)
`ifdef ONC_PARITY_EN
    , .onc_parity_err(onc_parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int effLen(input logic [2:0] len);
    if (len == 3'd0) return 1;
    if (int'(len) > MAXB) return MAXB;
    return int'(len);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuiet(input string tag);
    check({tag, "_busy"},  onc_busy, 1'b0);
    check({tag, "_valid"}, onc_rdata_valid, 1'b0);
    check({tag, "_resp"},  onc_resp, 1'b0);
    check({tag, "_wrdy"},  onc_wdata_ready, 1'b0);
    check({tag, "_rdata"}, onc_rdata, '0);
  endtask

  // Burst write of wbuf[0..n-1]; cycle c after acceptance consumes wbuf[c] at the next edge.
  task automatic doWrite(input logic [AW-1:0] a, input logic [2:0] len);
    int n = effLen(len);
    onc_write = 1'b1; onc_read = 1'b0; onc_addr = a; onc_burst_len = len;
    tick();
    onc_addr = $urandom; onc_burst_len = 3'($urandom);
    for (int c = 0; c <= n; c++) begin
      check("wr_ready", onc_wdata_ready, c < n);
      check("wr_resp",  onc_resp, c == n - 1);
      check("wr_busy",  onc_busy, 1'b1);
      check("wr_valid", onc_rdata_valid, 1'b0);
      if (c < n) begin
        onc_wdata = wbuf[c];
        model[8'(int'(a) + c)]   = wbuf[c];
        written[8'(int'(a) + c)] = 1'b1;
        tick();
      end
    end
    onc_write = 1'b0; onc_wdata = $urandom;
    tick();
    check("wr_idle", onc_busy, 1'b0);
  endtask

  // Read: first beat in cycle LAT after acceptance, n back-to-back beats, then DONE held for 'hold' cycles.
  task automatic doRead(input logic [AW-1:0] a, input logic [2:0] len, input int hold, input bit alsoWrite);
    int n = effLen(len);
    logic [7:0] ba;
    onc_read = 1'b1; onc_write = alsoWrite; onc_addr = a; onc_burst_len = len;
    onc_wdata = $urandom;
    tick();
    onc_addr = $urandom; onc_burst_len = 3'($urandom);
    for (int c = 0; c <= LAT + n; c++) begin
      ba = 8'(int'(a) + c - LAT);
      check("rd_valid", onc_rdata_valid, (c >= LAT) && (c < LAT + n));
      check("rd_resp",  onc_resp, c == LAT + n - 1);
      check("rd_busy",  onc_busy, 1'b1);
      check("rd_wrdy",  onc_wdata_ready, 1'b0);
      if (c >= LAT && c < LAT + n && written[ba]) check("rd_data", onc_rdata, model[ba]);
      if (c == LAT + n) check("rd_done_data", onc_rdata, '0);
`ifdef ONC_PARITY_EN
      check("rd_perr", onc_parity_err, (c >= LAT) && (c < LAT + n) && (int'(ba) == corruptAddr));
`endif
      if (c < LAT + n) tick();
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_busy",  onc_busy, 1'b1);
      check("hold_valid", onc_rdata_valid, 1'b0);
      check("hold_resp",  onc_resp, 1'b0);
    end
    onc_read = 1'b0; onc_write = 1'b0;
    tick();
    check("rd_idle", onc_busy, 1'b0);
  endtask

  task automatic applyStimulus();
    logic [AW-1:0] ra;
    // Reset state
    rst = 1'b1; onc_read = 1'b0; onc_write = 1'b0; onc_addr = '0; onc_burst_len = '0; onc_wdata = '0;
    tick(); tick();
    checkQuiet("reset");
    @(negedge clk); rst = 1'b0;
    tick();
    checkQuiet("post_reset");

    // Reset during RD_WAIT aborts; data survives
    wbuf[0] = 32'hDEADBEEF;
    doWrite(8'h10, 3'd1);
    onc_read = 1'b1; onc_addr = 8'h10; onc_burst_len = 3'd1;
    tick();
    check("rdwait_busy", onc_busy, 1'b1);
    rst = 1'b1;
    #1;
    checkQuiet("mid_reset");
    onc_read = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick();
    checkQuiet("after_abort");
    doRead(8'h10, 3'd1, 0, 1'b0);

    // Single read latency
    wbuf[0] = 32'h12345678;
    doWrite(8'h05, 3'd1);
    doRead(8'h05, 3'd1, 0, 1'b0);

    // Write burst with address wrap
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
    doWrite(8'hFE, 3'd4);
    doRead(8'hFE, 3'd4, 0, 1'b0);

    // Burst length edge values
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    doWrite(8'h50, 3'd7);
    check("clamp_no_5th", written[8'h54], 1'b0);
    doRead(8'h50, 3'd0, 0, 1'b0);
    doRead(8'h50, 3'd7, 0, 1'b0);

    // Simultaneous requests: read wins, array unchanged; then held request
    wbuf[0] = 32'h2020CAFE;
    doWrite(8'h20, 3'd1);
    doRead(8'h20, 3'd1, 0, 1'b1);
    doRead(8'h20, 3'd1, 0, 1'b0);
    doRead(8'h05, 3'd1, 3, 1'b0);

    // Randomized traffic confined to a small window so reads hit written data
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      ra = 8'h80 + 8'($urandom_range(0, 15));
      doWrite(ra, 3'($urandom_range(0, 7)));
      ra = 8'h80 + 8'($urandom_range(0, 15));
      doRead(ra, 3'($urandom_range(0, 7)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

`ifdef ONC_PARITY_EN
    wbuf[0] = 32'h00000001;
    doWrite(8'h30, 3'd1);
    force dut.r_par[8'h30] = 1'b0;
    corruptAddr = 8'h30;
    doRead(8'h30, 3'd1, 0, 1'b0);
    release dut.r_par[8'h30];
    corruptAddr = -1;
    doRead(8'h31, 3'd1, 0, 1'b0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) written[i] = 1'b0;
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
